// File: rtl/hp_sample_queue.sv
// hp_sample_queue
//   Circular stereo sample buffer that feeds a high-pass FIR. Once FILL samples
//   are stored, every further write starts a readout that streams TAPS samples,
//   oldest first, while holding sequencing high for TAPS+1 cycles. Each readout
//   retires the oldest sample (old_ptr advances by one).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wrt_smpl              one-cycle write strobe for lft_smpl/rght_smpl
//   lft_smpl, rght_smpl   signed 16-bit stereo input sample
//   lft_out, rght_out     registered sample stream, held while sequencing is low
//   sequencing            high for the duration of a readout
//   ovr                   sticky overrun flag (HPQ_OVR_EN builds only)
//
// Build option
//   HPQ_OVR_EN  when defined, adds the ovr port: set by any write that lands
//               during a readout, cleared only by reset.
//
// Read path: RAM read register (rd_q, no reset so it maps onto block RAM) then
// the output register. rd_addr therefore runs one address ahead of the sample
// that is presented: it idles at old_ptr, so the first sample is already in
// rd_q when the readout starts, and cycle-0 output is the stale held value.
module hp_sample_queue #(
  parameter int DEPTH = 1536,
  parameter int FILL  = 1531,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
`ifdef HPQ_OVR_EN
  output logic               ovr,
`endif
  output logic               sequencing
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILL + 1);
  localparam int CW = $clog2(TAPS + 1);

  typedef struct packed {
    logic signed [15:0] lft;
    logic signed [15:0] rght;
  } smpl_t;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  smpl_t          mem [DEPTH];
  smpl_t          rd_q;
  logic [AW-1:0]  new_ptr, old_ptr, rd_addr;
  logic [FW-1:0]  fill_cnt;
  logic [CW-1:0]  cnt;
  state_t         state, nxt_state;
  logic           trig, last;

  // Only a write seen in IDLE with the buffer already full starts a readout;
  // writes during READ are stored but never queue another one.
  assign trig = wrt_smpl && (fill_cnt == FW'(FILL)) && (state == IDLE);
  assign last = (state == READ) && (cnt == CW'(TAPS));

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (trig) nxt_state = READ;
      READ:    if (last) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sequencing <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= nxt_state;
      sequencing <= (nxt_state == READ);
      cnt        <= (state == READ && !last) ? cnt + CW'(1) : '0;
    end
  end

  // Storage: read-before-write; the guard gap keeps new_ptr off the live window.
  always_ff @(posedge clk) begin
    if (wrt_smpl) mem[new_ptr] <= '{lft: lft_smpl, rght: rght_smpl};
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr  <= '0;
      old_ptr  <= '0;
      rd_addr  <= '0;
      fill_cnt <= '0;
    end else begin
      if (wrt_smpl) new_ptr <= wrap_inc(new_ptr);
      if (wrt_smpl && fill_cnt != FW'(FILL)) fill_cnt <= fill_cnt + FW'(1);
      if (last) begin
        old_ptr <= wrap_inc(old_ptr);
        rd_addr <= wrap_inc(old_ptr);   // park on the new oldest sample
      end else if (nxt_state == READ) begin
        rd_addr <= wrap_inc(rd_addr);
      end
    end
  end

  // Load outputs for cycles 1..TAPS only; they hold once sequencing drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out  <= '0;
      rght_out <= '0;
    end else if (state == READ && !last) begin
      lft_out  <= rd_q.lft;
      rght_out <= rd_q.rght;
    end
  end

`ifdef HPQ_OVR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovr <= 1'b0;
    else if (wrt_smpl && sequencing) ovr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hp_sample_queue.sv
module tb_hp_sample_queue;
  localparam int D_FILL  = 1531;
  localparam int D_TAPS  = 1021;
  localparam int S_DEPTH = 16;
  localparam int S_FILL  = 11;
  localparam int S_TAPS  = 6;
  localparam int NV      = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_wrt = 1'b0, s_wrt = 1'b0;
  logic signed [15:0] d_l = '0, d_r = '0, s_l = '0, s_r = '0;
  logic signed [15:0] d_lo, d_ro, s_lo, s_ro;
  logic d_seq, s_seq;
`ifdef HPQ_OVR_EN
  logic d_ovr, s_ovr;
`endif

  bit sel = 1'b0;
  logic signed [15:0] m_l, m_r;
  logic m_seq;
  assign m_l   = sel ? s_lo  : d_lo;
  assign m_r   = sel ? s_ro  : d_ro;
  assign m_seq = sel ? s_seq : d_seq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hp_sample_queue u_dflt (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(d_wrt), .lft_smpl(d_l), .rght_smpl(d_r),
    .lft_out(d_lo), .rght_out(d_ro),
`ifdef HPQ_OVR_EN
    .ovr(d_ovr),
`endif
    .sequencing(d_seq)
  );

  hp_sample_queue #(.DEPTH(S_DEPTH), .FILL(S_FILL), .TAPS(S_TAPS)) u_small (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(s_wrt), .lft_smpl(s_l), .rght_smpl(s_r),
    .lft_out(s_lo), .rght_out(s_ro),
`ifdef HPQ_OVR_EN
    .ovr(s_ovr),
`endif
    .sequencing(s_seq)
  );

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    bit                 exp_rd;
    int                 base;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_write(input bit sm, input logic signed [15:0] l, input logic signed [15:0] r);
    @(negedge clk);
    if (sm) begin s_wrt = 1'b1; s_l = l; s_r = r; end
    else    begin d_wrt = 1'b1; d_l = l; d_r = r; end
    @(negedge clk);
    s_wrt = 1'b0;
    d_wrt = 1'b0;
  endtask

  // Write one sample, then watch the readout window. base = sample number shown
  // in sequencing cycle 1 (left = n, right = -n). act 1: reset at cycle act_k;
  // act 2: extra write at cycle act_k.
  task automatic readout(input bit sm, input logic signed [15:0] l, input logic signed [15:0] r,
                         input bit exp_rd, input int base, input int act_k, input int act);
    int taps;
    int nseq;
    bit wpend;
    logic signed [15:0] e;
    taps  = sm ? S_TAPS : D_TAPS;
    nseq  = 0;
    wpend = 1'b0;
    sel   = sm;
    pulse_write(sm, l, r);
    if (!exp_rd) begin
      chk("idle_seq", int'(m_seq), 0);
      return;
    end
    for (int c = 0; c < taps + 4; c++) begin
      if (wpend) begin d_wrt = 1'b0; wpend = 1'b0; end
      if (m_seq) begin
        if (nseq >= 1) begin
          e = 16'(base + nseq - 1);
          chk("rd_lft", int'(m_l), int'(e));
          chk("rd_rght", int'(m_r), -int'(e));
        end
        nseq++;
      end
`ifdef HPQ_OVR_EN
      if (act == 2 && c == act_k + 1) chk("ovr_set", int'(d_ovr), 1);
`endif
      if (act == 1 && c == act_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort_seq", int'(m_seq), 0);
        chk("abort_lft", int'(m_l), 0);
        chk("abort_rght", int'(m_r), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (act == 2 && c == act_k) begin
        d_wrt = 1'b1; d_l = 16'sh7fff; d_r = 16'sh7ffe; wpend = 1'b1;
      end
      @(negedge clk);
    end
    chk("seq_len", nseq, taps + 1);
    e = 16'(base + taps - 1);
    chk("hold_lft", int'(m_l), int'(e));
    chk("hold_rght", int'(m_r), -int'(e));
  endtask

  initial begin
    // Small instance: sample n lands at (n-1) mod 16; write n >= 12 starts
    // readout n-12, whose oldest sample is number n-11. Wraps several times.
    for (int i = 0; i < NV; i++) begin
      tbl[i].l      = 16'(i + 1);
      tbl[i].r      = 16'(-(i + 1));
      tbl[i].exp_rd = (i + 1) >= S_FILL + 1;
      tbl[i].base   = (i + 1) - S_FILL;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_d_seq", int'(d_seq), 0);
    chk("rst_d_lft", int'(d_lo), 0);
    chk("rst_d_rght", int'(d_ro), 0);
    chk("rst_s_seq", int'(s_seq), 0);
`ifdef HPQ_OVR_EN
    chk("rst_ovr", int'(d_ovr), 0);
`endif
    rst_n = 1'b1;

    // Fill to FILL with no readout, then the first three readouts.
    for (int n = 1; n <= D_FILL; n++) readout(0, 16'(n), 16'(-n), 0, 0, 0, 0);
    readout(0, 16'(1532), 16'(-1532), 1, 1, 0, 0);
    readout(0, 16'(1533), 16'(-1533), 1, 2, 0, 0);
    readout(0, 16'(1534), 16'(-1534), 1, 3, 500, 1);

    // After the abort, the fill count restarts; new values expose stale reads.
    for (int n = 2001; n <= 2000 + D_FILL; n++) readout(0, 16'(n), 16'(-n), 0, 0, 0, 0);
    readout(0, 16'(3532), 16'(-3532), 1, 2001, 0, 0);

    // Write during readout: stored, no extra readout, sets ovr when present.
    readout(0, 16'(3533), 16'(-3533), 1, 2002, 300, 2);
`ifdef HPQ_OVR_EN
    repeat (4) @(negedge clk);
    chk("ovr_sticky", int'(d_ovr), 1);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst2_seq", int'(d_seq), 0);
    chk("rst2_lft", int'(d_lo), 0);
`ifdef HPQ_OVR_EN
    chk("rst2_ovr", int'(d_ovr), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Small-geometry wrap test, table driven.
    for (int i = 0; i < NV; i++)
      readout(1, tbl[i].l, tbl[i].r, tbl[i].exp_rd, tbl[i].base, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hp_sample_queue.md
HP_SAMPLE_QUEUE -- requirements
Module: hp_sample_queue

Interface
REQ-001 Parameter DEPTH, default 1536, circular buffer depth in stereo sample pairs.
REQ-002 Parameter FILL, default 1531, stored-sample count at which readouts begin.
REQ-003 Parameter TAPS, default 1021, samples delivered per readout (equals downstream FIR coefficient count).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wrt_smpl  input  1  one-cycle pulse; new stereo sample valid on lft_smpl/rght_smpl.
REQ-007 lft_smpl  input  16  signed left sample.
REQ-008 rght_smpl  input  16  signed right sample.
REQ-009 lft_out  output  16  signed left sample stream to downstream high-pass FIR.
REQ-010 rght_out  output  16  signed right sample stream to downstream high-pass FIR.
REQ-011 sequencing  output  1  high while a readout is in progress; drives the FIR's sequencing input.
REQ-012 ovr  output  1  sticky overrun flag; port exists only when HPQ_OVR_EN is defined.

Function
REQ-013 Storage: DEPTH x 32-bit array (left in [31:16], right in [15:0]); single write port, single synchronous read port.
REQ-014 Pointers new_ptr (write) and old_ptr (oldest sample), 11 bits each; each increments modulo DEPTH, wrapping DEPTH-1 -> 0.
REQ-015 On every wrt_smpl: write {lft_smpl,rght_smpl} at new_ptr, then advance new_ptr; writes are never refused.
REQ-016 Fill counter saturates at FILL; increments on each wrt_smpl while below FILL.
REQ-017 FSM states IDLE and READ; reset state IDLE.
REQ-018 IDLE -> READ in the cycle after a wrt_smpl that finds the counter already at FILL (the (FILL+1)th and every later write); otherwise remain IDLE.
REQ-019 In READ, sequencing is high for exactly TAPS+1 (1022) consecutive cycles, then low; FSM returns to IDLE.
REQ-020 Data alignment: in sequencing cycle k (k = 0..TAPS), for k >= 1, lft_out/rght_out = sample stored at (old_ptr + k - 1) mod DEPTH, where old_ptr is its value at readout start; cycle-0 data is don't-care.
REQ-021 Read address wraps modulo DEPTH exactly like the pointers.
REQ-022 When a readout ends, old_ptr advances by exactly 1.
REQ-023 A wrt_smpl during READ is written normally (REQ-015) but does not trigger or queue another readout.
REQ-024 Outputs are registered; lft_out/rght_out hold their last value when sequencing is low.
REQ-025 Invariant: new_ptr never enters the address range of the active readout (DEPTH - FILL >= 5 guard gap).

Reset
REQ-026 rst_n low: immediately clear new_ptr, old_ptr, fill counter and read address to 0; set FSM to IDLE, sequencing to 0, lft_out/rght_out to 0 and ovr (if present) to 0.
REQ-027 Reset asserted mid-readout aborts it: sequencing drops asynchronously, and no old_ptr advance occurs.
REQ-028 Array contents are not reset; stale data is unobservable because the fill counter restarts at 0.

Configuration
REQ-029 Macro HPQ_OVR_EN: when defined, the ovr port exists and is set on any wrt_smpl that arrives while sequencing is high; it stays set until reset.
REQ-030 When HPQ_OVR_EN is not defined, the ovr port and its logic are absent; all other behaviour is identical.

Verification
REQ-031 Write samples 1..1531 (left = n, right = -n) -> sequencing never asserts.
REQ-032 Write sample 1532 -> sequencing high for exactly 1022 cycles; cycles 1..1021 output left = 1..1021, right = -1..-1021.
REQ-033 Write sample 1533 after the readout completes -> next readout outputs left = 2..1022 (old_ptr advanced by 1).
REQ-034 Stream 3100 samples, one per 1100 cycles -> new_ptr wraps past 1535; a readout starting at old_ptr = 1530 outputs addresses 1530..1535, then 0..1014, in order, with no glitch.
REQ-035 Pulse rst_n low at readout cycle 500 -> sequencing = 0 and outputs = 0 at once; after release, no readout until 1532 more writes.
REQ-036 With HPQ_OVR_EN defined, pulse wrt_smpl at readout cycle 300 -> ovr = 1 from the next cycle until reset, no extra readout; without the macro, the same stimulus produces identical sequencing and data.
